uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter DBITS, default 8: data bits per frame.
REQ-002 Parameter SB_TICK, default 16: sample ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter BR_BITS, default 6: width of the baud divider counter.
REQ-004 Parameter BR_LIMIT, default 53: baud divider modulus (clocks per sample tick); 16 ticks per bit.
REQ-005 Port clk, input, 1: single clock.
REQ-006 Port reset, input, 1: synchronous reset, active-high.
REQ-007 Port tx_start, input, 1: frame request, level-sensitive.
REQ-008 Port data_in, input, DBITS: character to send.
REQ-009 Port tx, output, 1: serial line, idle high.
REQ-010 Port tx_done, output, 1: one-clock pulse at frame end.
REQ-011 Port sample_tick, output, 1: internal 16x baud tick, exposed for observation.
REQ-012 There is one clock, clk; reset is synchronous and active-high; all state updates on the rising edge of clk.

Function
REQ-013 Baud divider: BR_BITS counter counts 0..BR_LIMIT-1 and wraps to 0; sample_tick is high exactly in cycles where the count equals BR_LIMIT-1, giving one tick per BR_LIMIT clocks.
REQ-014 FSM states are IDLE, START, DATA, STOP; tx is driven from a register (no combinational glitches).
REQ-015 IDLE: tx=1; when sample_tick and tx_start are both high, capture data_in into the shift register, clear the tick and bit counters, and go to START.
REQ-016 START: tx=0 for 16 ticks, then go to DATA.
REQ-017 DATA: tx = shift register bit 0, LSB first; after 16 ticks shift right and increment the bit count; after DBITS bits go to STOP.
REQ-018 STOP: tx=1 for SB_TICK ticks; on the last tick go to IDLE and assert tx_done for exactly that one clock.
REQ-019 Bit time is 16*BR_LIMIT clocks (848 at defaults); a default frame is 10 bits = 8480 clocks.
REQ-020 data_in changes and tx_start deassertion after capture are ignored until the frame completes.
REQ-021 tx_start held high gives back-to-back frames; the next start bit begins at the first tick after returning to IDLE, which also lets an upstream register update data_in after tx_done.
REQ-022 tx_start low in IDLE keeps tx=1 indefinitely; the divider free-runs in every state.

Reset
REQ-023 With reset high at a clk edge: state=IDLE, tx=1, tx_done=0, divider count=0, tick/bit counters=0, shift register=0.
REQ-024 Reset mid-frame aborts the frame: tx=1 on that edge and no tx_done for the aborted frame.
REQ-025 After reset is released, the first sample_tick occurs BR_LIMIT-1 clocks later.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, a PARITY state is inserted between DATA and STOP that drives the even-parity bit (XOR of the captured data) for 16 ticks; the frame is 11 bits at defaults.
REQ-027 Without UART_TX_PARITY_EN, there is no PARITY state; DATA goes directly to STOP.

Verification
REQ-028 Reset held 3 clocks then released -> tx=1, tx_done=0; sample_tick pulses every 53 clocks, first one 52 clocks after release.
REQ-029 data_in=0x49, tx_start pulsed high through one tick -> tx sequence 0,1,0,0,1,0,0,1,0,1 with each bit 848 clocks; single tx_done pulse at the end.
REQ-030 tx_start held high, data_in changed from 0x49 to 0x6E one clock after tx_done -> second frame carries 0x6E; idle gap ≤53 clocks; two tx_done pulses total.
REQ-031 Reset asserted during DATA bit 3 -> tx=1 on that edge; no tx_done; a new frame with 0x55 then completes normally.
REQ-032 UART_TX_PARITY_EN defined, data_in=0x07 -> parity bit 1 after the data bits, then stop; frame is 9328 clocks.
REQ-033 data_in toggled and tx_start dropped mid-frame -> transmitted bits are unchanged from the captured value.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// -----------------------------------------------------------------------------
// uart_transmitter_if
// Signal bundle between a character source and the UART transmitter.
//
//   tx_start    : frame request from the source (level-sensitive)
//   data_in     : character to send, DBITS wide
//   tx          : serial line, idle high
//   tx_done     : one-clock pulse at the end of each frame
//   sample_tick : 16x baud tick, exposed for observation
//
// Modports:
//   master : the character source (drives tx_start/data_in)
//   slave  : the transmitter (drives tx/tx_done/sample_tick)
// -----------------------------------------------------------------------------
interface uart_transmitter_if #(
    parameter int DBITS = 8
);
    logic             tx_start;
    logic [DBITS-1:0] data_in;
    logic             tx;
    logic             tx_done;
    logic             sample_tick;

    modport master (
        output tx_start,
        output data_in,
        input  tx,
        input  tx_done,
        input  sample_tick
    );

    modport slave (
        input  tx_start,
        input  data_in,
        output tx,
        output tx_done,
        output sample_tick
    );
endinterface

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// UART serialiser with a free-running baud divider producing a 16x sample tick.
// Frame: start bit (0), DBITS data bits LSB first, optional even-parity bit,
// stop bit(s) lasting SB_TICK sample ticks.
//
// Parameters:
//   DBITS    : data bits per frame
//   SB_TICK  : sample ticks in the stop period (16 = 1, 24 = 1.5, 32 = 2 bits)
//   BR_BITS  : width of the baud divider counter
//   BR_LIMIT : baud divider modulus (clocks per sample tick)
//
// Ports:
//   clk   : single clock, all state updates on its rising edge
//   reset : synchronous reset, active-high
//   bus   : uart_transmitter_if.slave (tx_start, data_in, tx, tx_done,
//           sample_tick)
//
// Build option:
//   UART_TX_PARITY_EN : when defined, a PARITY state sends the even-parity bit
//                       of the captured character between DATA and STOP.
// -----------------------------------------------------------------------------
module uart_transmitter #(
    parameter int DBITS    = 8,
    parameter int SB_TICK  = 16,
    parameter int BR_BITS  = 6,
    parameter int BR_LIMIT = 53
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_transmitter_if.slave    bus
);

    // Tick counter must hold both 15 (one bit time) and SB_TICK-1.
    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = $clog2(DBITS + 1);

    localparam logic [BR_BITS-1:0] BR_LAST     = BR_BITS'(BR_LIMIT - 1);
    localparam logic [S_W-1:0]     S_LAST_BIT  = S_W'(15);
    localparam logic [S_W-1:0]     S_LAST_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0]     N_LAST      = N_W'(DBITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [BR_BITS-1:0] br_cnt_reg, br_cnt_next;
    logic               tick;

    state_t             state_reg, state_next;
    logic [S_W-1:0]     s_reg, s_next;
    logic [N_W-1:0]     n_reg, n_next;
    logic [DBITS-1:0]   b_reg, b_next;
    logic               tx_reg, tx_next;
    logic               done;
`ifdef UART_TX_PARITY_EN
    // The shift register is consumed during DATA, so parity is taken at capture.
    logic               par_reg, par_next;
`endif

    // -------------------------------------------------------------------------
    // Baud divider: free-runs in every state, one tick per BR_LIMIT clocks.
    // -------------------------------------------------------------------------
    assign tick        = (br_cnt_reg == BR_LAST);
    assign br_cnt_next = tick ? '0 : br_cnt_reg + 1'b1;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_reg <= '0;
            state_reg  <= IDLE;
            s_reg      <= '0;
            n_reg      <= '0;
            b_reg      <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_reg    <= 1'b0;
`endif
        end else begin
            br_cnt_reg <= br_cnt_next;
            state_reg  <= state_next;
            s_reg      <= s_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
            tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
            par_reg    <= par_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        done       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next   = par_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (tick && bus.tx_start) begin
                    state_next = START;
                    s_next     = '0;
                    n_next     = '0;
                    b_next     = bus.data_in;
`ifdef UART_TX_PARITY_EN
                    par_next   = ^bus.data_in;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        state_next = DATA;
                        s_next     = '0;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        state_next = STOP;
                        s_next     = '0;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_reg == S_LAST_STOP) begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Line level is decoded from the state being entered, so the registered tx
    // changes on the same edge as the state register.
    // -------------------------------------------------------------------------
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = par_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign bus.tx          = tx_reg;
    assign bus.tx_done     = done;
    assign bus.sample_tick = tick;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Directed bench for uart_transmitter at default parameters. Frames are
// checked bit by bit at the first and last clock of every bit period.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int BR_LIMIT = 53;
    localparam int BIT      = 16 * BR_LIMIT;   // 848 clocks per bit
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int PB = (NB == 11) ? 1 : 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_transmitter_if #(.DBITS(8)) bus();

    uart_transmitter #(
        .DBITS   (8),
        .SB_TICK (16),
        .BR_BITS (6),
        .BR_LIMIT(BR_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0;
    int last_done_cyc = -1;
    always @(negedge clk) begin
        if (bus.tx_done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    int total = 0;
    int bad   = 0;

    // seq: transmitted order, bit 0 = start bit, bits 8:1 = data LSB first,
    // bit 9 = stop bit. par: expected even-parity bit.
    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;
        logic       par;
        bit         disturb;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic fbit(input logic [9:0] seq, input logic par, input int i);
        if (PB == 1 && i == 9) return par;
        if (i == NB - 1) return seq[9];
        return seq[i];
    endfunction

    task automatic wait_start(input string tag, output int s);
        s = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin
                s = cyc;
                break;
            end
        end
        total++;
        if (s < 0) begin
            bad++;
            $display("FAIL %s start_timeout: got no start bit expected start within 200 clocks", tag);
        end
    endtask

    task automatic check_frame(input logic [9:0] seq, input logic par, input bit hold,
                               input bit disturb, input string tag, output int s);
        int   d0;
        logic a, b, e;
        wait_start(tag, s);
        if (s < 0) return;
        if (!hold) bus.tx_start = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < NB; i++) begin
            e = fbit(seq, par, i);
            wait_cyc(s + i * BIT);
            a = bus.tx;
            if (disturb && i == 3) begin
                bus.data_in  = ~bus.data_in;
                bus.tx_start = 1'b0;
            end
            wait_cyc(s + i * BIT + BIT - 1);
            b = bus.tx;
            check($sformatf("%s bit%0d first/last", tag, i), {30'd0, a, b}, {30'd0, e, e});
        end
        @(negedge clk);
        #1;
        check($sformatf("%s done_count", tag), done_cnt - d0, 1);
        check($sformatf("%s done_cycle", tag), last_done_cyc, s + NB * BIT - 1);
        $display("frame %s start=%0d bits=%0d done=%0d", tag, s, NB, last_done_cyc);
    endtask

    task automatic wait_tick(output int t);
        t = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.sample_tick === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        int r, t, t2, s, s1, s2, d0, viol;

        vecs[0] = '{data: 8'h49, seq: 10'h292, par: 1'b1, disturb: 1'b0};
        vecs[1] = '{data: 8'h00, seq: 10'h200, par: 1'b0, disturb: 1'b0};
        vecs[2] = '{data: 8'hFF, seq: 10'h3FE, par: 1'b0, disturb: 1'b0};
        vecs[3] = '{data: 8'h07, seq: 10'h20E, par: 1'b1, disturb: 1'b1};

        bus.tx_start = 1'b0;
        bus.data_in  = 8'h00;
        reset        = 1'b1;

        // Reset held for three clocks.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx", bus.tx, 1);
        check("reset tx_done", bus.tx_done, 0);
        check("reset sample_tick", bus.sample_tick, 0);
        r = cyc;
        reset = 1'b0;

        wait_tick(t);
        check("first tick after release", t - r, 52);
        wait_tick(t2);
        check("tick interval 1", t2 - t, 53);
        wait_tick(t);
        check("tick interval 2", t - t2, 53);
        $display("reset release=%0d first tick period checks done", r);

        // Idle line with tx_start low.
        viol = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.tx_done !== 1'b0) viol++;
        end
        check("idle line stays high", viol, 0);

        // Table-driven single frames with a pulsed request.
        for (int i = 0; i < 4; i++) begin
            bus.data_in  = vecs[i].data;
            bus.tx_start = 1'b1;
            check_frame(vecs[i].seq, vecs[i].par, 1'b0, vecs[i].disturb,
                        $sformatf("vec%0d_%02h", i, vecs[i].data), s);
        end

        // Back-to-back: request held, data updated one clock after tx_done.
        bus.data_in  = 8'h49;
        bus.tx_start = 1'b1;
        check_frame(10'h292, 1'b1, 1'b1, 1'b0, "b2b_49", s1);
        bus.data_in = 8'h6E;
        check_frame(10'h2DC, 1'b1, 1'b0, 1'b0, "b2b_6E", s2);
        check("b2b idle gap", s2 - (s1 + NB * BIT), 53);
        d0 = done_cnt;
        viol = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) viol++;
        end
        check("b2b no third frame tx", viol, 0);
        check("b2b no third frame done", done_cnt - d0, 0);

        // Reset during data bit 3 (transmit index 4) of 0xA3, whose bit 3 is 0.
        bus.data_in  = 8'hA3;
        bus.tx_start = 1'b1;
        wait_start("abort_A3", s);
        bus.tx_start = 1'b0;
        if (s >= 0) begin
            wait_cyc(s + 4 * BIT + 400);
            check("abort pre-reset tx", bus.tx, 0);
            d0 = done_cnt;
            reset = 1'b1;
            @(posedge clk);
            #1;
            check("abort tx on reset edge", bus.tx, 1);
            check("abort tx_done on reset edge", bus.tx_done, 0);
            @(negedge clk);
            r = cyc;
            reset = 1'b0;
            wait_tick(t);
            check("abort first tick after release", t - r, 52);
            viol = 0;
            while (cyc < s + NB * BIT + 200) begin
                @(negedge clk);
                if (bus.tx !== 1'b1) viol++;
            end
            check("abort line stays high", viol, 0);
            check("abort no tx_done", done_cnt - d0, 0);
            $display("abort frame start=%0d reset_release=%0d", s, r);
        end

        bus.data_in  = 8'h55;
        bus.tx_start = 1'b1;
        check_frame(10'h2AA, 1'b0, 1'b0, 1'b0, "post_reset_55", s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
